// File: rtl/cpu_pkg.sv
// Shared constants, ALU opcodes and the decoded control bundle for the integer pipeline.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int RA_W   = 5;
  localparam int ALUC_W = 3;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALUC_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [ALUC_W-1:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                 alu_src: 1'b0, alu_control: ALU_ADD};

  // A producer matches an operand only when it writes a non-zero register equal to rs.
  function automatic logic rs_hit(input logic            wr_en,
                                  input logic [RA_W-1:0] wr_rd,
                                  input logic [RA_W-1:0] rs);
    return wr_en && (wr_rd == rs) && (rs != {RA_W{1'b0}});
  endfunction

endpackage

// File: rtl/forward_mux.sv
// Per-operand bypass selector: picks the newest in-flight result for a source register.
module forward_mux
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] stored,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd
);

  // EX/MEM is younger than MEM/WB, so it takes precedence over both other sources.
  always_comb begin
    if (rs_hit(mem_reg_write, mem_rd, rs)) begin
      fwd = mem_result;
    end else if (rs_hit(wb_reg_write, wb_rd, rs)) begin
      fwd = wb_result;
    end else begin
      fwd = stored;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute register feeding the ALU: forwarding, B-operand select,
// load-use bubble insertion, flush and valid/ready flow control.
module alu_issue_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [RA_W-1:0]   in_rs1,
  input  logic [RA_W-1:0]   in_rs2,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_alu_src,
  input  logic [ALUC_W-1:0] in_alu_control,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_src_a,
  output logic [XLEN-1:0]   out_src_b,
  output logic [ALUC_W-1:0] out_alu_control,
  output logic [XLEN-1:0]   out_store_data,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [XLEN-1:0]   out_pc
);

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;

  ctrl_t           in_ctrl_s;
  logic            adv_s, lu_s;
  logic [XLEN-1:0] fwd_a_s, fwd_b_s;

  assign in_ctrl_s = '{reg_write: in_reg_write, mem_read: in_mem_read, mem_write: in_mem_write,
                       alu_src: in_alu_src, alu_control: in_alu_control};

  assign adv_s = !valid_q || out_ready;

  // rs2 only matters to the consumer when it feeds B or supplies store data.
  assign lu_s = valid_q && ctrl_q.mem_read && (rd_q != {RA_W{1'b0}}) && in_valid &&
                ((in_rs1 == rd_q) || ((in_rs2 == rd_q) && (!in_alu_src || in_mem_write)));

  assign in_ready = adv_s && !lu_s && !flush && !rst;

  // Next-state selection: flush, then bubble, then capture, else hold with WB refresh.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv_s && lu_s) begin
      valid_d = 1'b0;
    end else if (adv_s) begin
      valid_d   = in_valid;
      ctrl_d    = in_ctrl_s;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      rd_d      = in_rd;
      rs1_val_d = in_rs1_val;
      rs2_val_d = in_rs2_val;
      imm_d     = in_imm;
      pc_d      = in_pc;
    end else begin
      // A long stall can outlast the WB stage; latch its result so the forward survives.
      if (rs_hit(wb_reg_write, wb_rd, rs1_q)) begin
        rs1_val_d = wb_result;
      end else begin
        rs1_val_d = rs1_val_q;
      end
      if (rs_hit(wb_reg_write, wb_rd, rs2_q)) begin
        rs2_val_d = wb_result;
      end else begin
        rs2_val_d = rs2_val_q;
      end
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      rs1_q     <= {RA_W{1'b0}};
      rs2_q     <= {RA_W{1'b0}};
      rd_q      <= {RA_W{1'b0}};
      rs1_val_q <= {XLEN{1'b0}};
      rs2_val_q <= {XLEN{1'b0}};
      imm_q     <= {XLEN{1'b0}};
      pc_q      <= {XLEN{1'b0}};
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
    end
  end

  forward_mux u_fwd_a (
    .rs            (rs1_q),
    .stored        (rs1_val_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .fwd           (fwd_a_s)
  );

  forward_mux u_fwd_b (
    .rs            (rs2_q),
    .stored        (rs2_val_q),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .fwd           (fwd_b_s)
  );

  assign out_valid       = valid_q;
  assign out_src_a       = fwd_a_s;
  assign out_src_b       = ctrl_q.alu_src ? imm_q : fwd_b_s;
  assign out_store_data  = fwd_b_s;
  assign out_alu_control = ctrl_q.alu_control;
  assign out_rd          = rd_q;
  assign out_pc          = pc_q;
  assign out_reg_write   = valid_q && ctrl_q.reg_write;
  assign out_mem_read    = valid_q && ctrl_q.mem_read;
  assign out_mem_write   = valid_q && ctrl_q.mem_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected results are queued at handshake
// and compared when the stage presents a consumed instruction.
module tb_alu_issue_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm, pc;
    logic        src;
    logic [2:0]  aluc;
    logic        rw, mr, mw;
  } instr_t;

  typedef struct packed {
    logic [31:0] a, b, sd, pc;
    logic [2:0]  aluc;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_alu_src, in_reg_write, in_mem_read, in_mem_write;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [2:0]  in_alu_control;
  logic        flush, mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        out_valid, out_ready, out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_src_a, out_src_b, out_store_data, out_pc;
  logic [2:0]  out_alu_control;
  logic [4:0]  out_rd;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_src(in_alu_src),
    .in_alu_control(in_alu_control), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_pc(in_pc),
    .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_src_a(out_src_a),
    .out_src_b(out_src_b), .out_alu_control(out_alu_control),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                                input logic src, input logic [2:0] aluc, input logic rw,
                                input logic mr, input logic mw, input logic [31:0] pc);
    instr_t i;
    i = '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, v1: v1, v2: v2, imm: imm, pc: pc,
          src: src, aluc: aluc, rw: rw, mr: mr, mw: mw};
    return i;
  endfunction

  function automatic exp_t ex(input instr_t i, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd);
    exp_t e;
    e = '{a: a, b: b, sd: sd, pc: i.pc, aluc: i.aluc, rd: i.rd, rw: i.rw, mr: i.mr, mw: i.mw};
    return e;
  endfunction

  task automatic drive(input instr_t i);
    in_valid       = i.v;
    in_rs1         = i.rs1;
    in_rs2         = i.rs2;
    in_rd          = i.rd;
    in_rs1_val     = i.v1;
    in_rs2_val     = i.v2;
    in_imm         = i.imm;
    in_pc          = i.pc;
    in_alu_src     = i.src;
    in_alu_control = i.aluc;
    in_reg_write   = i.rw;
    in_mem_read    = i.mr;
    in_mem_write   = i.mw;
  endtask

  task automatic clear_fwd();
    mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
    wb_reg_write  = 1'b0; wb_rd  = 5'd0; wb_result  = 32'h0;
  endtask

  // Consumer side: every instruction taken by downstream must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected observed=pc %h expected=no output", out_pc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_src_a", out_src_a, e.a);
        chk("sb_src_b", out_src_b, e.b);
        chk("sb_store_data", out_store_data, e.sd);
        chk("sb_pc", out_pc, e.pc);
        chk("sb_alu_control", {29'd0, out_alu_control}, {29'd0, e.aluc});
        chk("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
        chk("sb_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write},
            {29'd0, e.rw, e.mr, e.mw});
      end
    end
  end

  initial begin
    instr_t i_basic, i_fwd, i_x0, i_lw, i_add, i_bp, i_fa, i_fb;
    i_basic = mk(5'd1, 5'd0, 5'd2, 32'd5, 32'h55, 32'd7, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 32'h100);
    i_fwd   = mk(5'd3, 5'd0, 5'd5, 32'h11, 32'h0, 32'h20, 1'b1, ALU_SUB, 1'b1, 1'b0, 1'b0, 32'h104);
    i_x0    = mk(5'd0, 5'd0, 5'd6, 32'h33, 32'h44, 32'h1, 1'b1, ALU_XOR, 1'b1, 1'b0, 1'b0, 32'h108);
    i_lw    = mk(5'd1, 5'd0, 5'd4, 32'h1000, 32'h0, 32'h8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 32'h200);
    i_add   = mk(5'd2, 5'd4, 5'd7, 32'h10, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 32'h204);
    i_bp    = mk(5'd1, 5'd6, 5'd8, 32'h2, 32'hBAD, 32'h0, 1'b0, ALU_OR, 1'b1, 1'b0, 1'b0, 32'h300);
    i_fa    = mk(5'd1, 5'd2, 5'd9, 32'h9, 32'h9, 32'h0, 1'b0, ALU_AND, 1'b1, 1'b0, 1'b0, 32'h400);
    i_fb    = mk(5'd1, 5'd2, 5'd10, 32'h9, 32'h9, 32'h0, 1'b0, ALU_AND, 1'b1, 1'b0, 1'b0, 32'h404);

    // Reset held two cycles with an instruction already offered.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    clear_fwd();
    drive(i_basic);
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_src_a", out_src_a, 32'd0);
    chk("rst_src_b", out_src_b, 32'd0);
    chk("rst_store_data", out_store_data, 32'd0);
    chk("rst_pc_rd_ctrl", {out_pc[26:0], out_rd} | {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'd0);

    // Basic issue right after release.
    rst = 1'b0;
    #1;
    chk("first_accept", {31'd0, in_ready}, 32'd1);
    sb_q.push_back(ex(i_basic, 32'd5, 32'd7, 32'h55));
    tick();
    chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_src_a", out_src_a, 32'd5);

    // Forward priority: held rs1=x3 with both MEM and WB writing x3.
    drive(i_fwd);
    #1;
    chk("fwd_accept", {31'd0, in_ready}, 32'd1);
    sb_q.push_back(ex(i_fwd, 32'hAA, 32'h20, 32'h0));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_reg_write  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'hBB;
    #1;
    chk("fwd_mem_over_wb", out_src_a, 32'hAA);
    mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_only", out_src_a, 32'hBB);
    mem_reg_write = 1'b1; out_ready = 1'b1;
    tick();
    clear_fwd();

    // x0 is never forwarded even when producers target x0.
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hCC;
    wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'hDD;
    drive(i_x0);
    #1;
    sb_q.push_back(ex(i_x0, 32'h33, 32'h1, 32'h44));
    tick();
    in_valid = 1'b0;
    #1;
    chk("x0_no_forward", out_src_a, 32'h33);
    tick();
    clear_fwd();

    // Load-use: lw x4 held, add reading x4 as B must bubble once.
    drive(i_lw);
    #1;
    sb_q.push_back(ex(i_lw, 32'h1000, 32'h8, 32'h0));
    tick();
    drive(i_add);
    #1;
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("lu_bubble_reg_write", {31'd0, out_reg_write}, 32'd0);
    chk("lu_release_in_ready", {31'd0, in_ready}, 32'd1);
    wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'h77;
    sb_q.push_back(ex(i_add, 32'h10, 32'h77, 32'h77));
    tick();
    in_valid = 1'b0;
    chk("lu_add_issued", {31'd0, out_valid}, 32'd1);
    tick();
    clear_fwd();

    // Backpressure: four stalled cycles, single WB pulse to held rs2=x6.
    drive(i_bp);
    #1;
    sb_q.push_back(ex(i_bp, 32'h2, 32'h1234, 32'h1234));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    wb_reg_write = 1'b1; wb_rd = 5'd6; wb_result = 32'h1234;
    #1;
    chk("bp_wb_forward", out_src_b, 32'h1234);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear_fwd();
    #1;
    chk("bp_refresh_held", out_src_b, 32'h1234);
    tick();
    tick();
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();

    // Flush with a valid held instruction, downstream ready and a new instruction offered.
    drive(i_fa);
    tick();
    drive(i_fb);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_kill_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_kill_reg_write", {31'd0, out_reg_write}, 32'd0);
    tick();
    chk("flush_no_capture", {31'd0, out_valid}, 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
